// File: rtl/seg_pkg.sv
// Shared constants and the digit-entry type for the multiplexed seven-segment driver.
package seg_pkg;

  localparam logic [3:0] CODE_MINUS = 4'd14;
  localparam logic [3:0] CODE_BLANK = 4'd15;

  // Active-low patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_MINUS = 7'h3F;
  localparam logic [6:0] SEG_OFF   = 7'h7F;

  typedef struct packed {
    logic [3:0] code;
    logic       dp;
  } digit_t;

  localparam digit_t DIGIT_BLANK = '{code: CODE_BLANK, dp: 1'b0};

endpackage

// File: rtl/seg_scan_if.sv
// Write/commit port of the display driver: shadow-buffer writes plus commit handshake.
interface seg_scan_if #(
  parameter int DIGITS = 8
) ();
  localparam int AW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [3:0]    wr_code;
  logic          wr_dp;
  logic          commit;
  logic          commit_done;
  logic          pending;

  modport master (
    output wr_en, wr_addr, wr_code, wr_dp, commit,
    input  commit_done, pending
  );

  modport slave (
    input  wr_en, wr_addr, wr_code, wr_dp, commit,
    output commit_done, pending
  );
endinterface

// File: rtl/seg_dec.sv
// Digit code to active-low seven-segment pattern; codes without a glyph stay dark.
module seg_dec
  import seg_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (code)
      4'd0:       seg = SEG_0;
      4'd1:       seg = SEG_1;
      4'd2:       seg = SEG_2;
      4'd3:       seg = SEG_3;
      4'd4:       seg = SEG_4;
      4'd5:       seg = SEG_5;
      4'd6:       seg = SEG_6;
      4'd7:       seg = SEG_7;
      4'd8:       seg = SEG_8;
      4'd9:       seg = SEG_9;
      CODE_MINUS: seg = SEG_MINUS;
      default:    seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg_scan.sv
// Time-multiplexed seven-segment driver: shadow/active digit buffers with frame-aligned
// commit, slot/digit scan counters and registered active-low segment/anode outputs.
module seg_scan
  import seg_pkg::*;
#(
  parameter int DIGITS = 8,
  parameter int DIV    = 1000,
  parameter int BLANK  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  seg_scan_if.slave         bus,
  output logic [6:0]        seg_n,
  output logic              dp_n,
  output logic [DIGITS-1:0] an_n,
  output logic              frame_start
);

  localparam int AW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;
  logic [AW-1:0] idx;
  digit_t        shadow [DIGITS];
  digit_t        active [DIGITS];
  logic          pending;
  logic          commit_done;

  logic          boundary;
  logic          wr_hit;
  logic          do_copy;
  digit_t        wr_entry;
  digit_t        cur;
  logic [6:0]    dec_seg;
  logic          lit;
  logic [DIGITS-1:0] an_sel;

  assign boundary = (cnt == CW'(DIV - 1)) && (idx == AW'(DIGITS - 1));
  assign wr_hit   = bus.wr_en && (int'(bus.wr_addr) < DIGITS);
  assign wr_entry = '{code: bus.wr_code, dp: bus.wr_dp};
  // A commit arriving on the boundary cycle itself is honoured immediately
  assign do_copy  = boundary && (pending || bus.commit);

  assign bus.pending     = pending;
  assign bus.commit_done = commit_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DIGITS; i++) shadow[i] <= DIGIT_BLANK;
    end else if (wr_hit) begin
      for (int unsigned i = 0; i < DIGITS; i++)
        if (bus.wr_addr == AW'(i)) shadow[i] <= wr_entry;
    end
  end

  // Same-cycle write is forwarded so the copy sees the value the shadow is about to take
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DIGITS; i++) active[i] <= DIGIT_BLANK;
    end else if (do_copy) begin
      for (int unsigned i = 0; i < DIGITS; i++)
        active[i] <= (wr_hit && bus.wr_addr == AW'(i)) ? wr_entry : shadow[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending     <= 1'b0;
      commit_done <= 1'b0;
    end else begin
      pending     <= do_copy ? 1'b0 : (pending | bus.commit);
      commit_done <= do_copy;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == CW'(DIV - 1)) begin
      cnt <= '0;
      idx <= (idx == AW'(DIGITS - 1)) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign cur = active[idx];
  assign lit = (cnt >= CW'(BLANK));

  seg_dec u_dec (
    .code (cur.code),
    .seg  (dec_seg)
  );

  always_comb begin
    an_sel      = '1;
    an_sel[idx] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_n        <= '1;
      seg_n       <= SEG_OFF;
      dp_n        <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      frame_start <= (cnt == '0) && (idx == '0);
      if (lit) begin
        an_n  <= an_sel;
        seg_n <= dec_seg;
        dp_n  <= ~cur.dp;
      end else begin
        an_n  <= '1;
        seg_n <= SEG_OFF;
        dp_n  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
// Directed bench for seg_scan: 4-digit main instance plus a 3-digit instance for
// out-of-range write addresses.
module tb_seg_scan;

  logic clk;
  logic rst_n;

  seg_scan_if #(.DIGITS(4)) bus_a ();
  seg_scan_if #(.DIGITS(3)) bus_b ();

  logic [6:0] seg_a, seg_b;
  logic       dp_a, dp_b;
  logic [3:0] an_a;
  logic [2:0] an_b;
  logic       fs_a, fs_b;

  seg_scan #(.DIGITS(4), .DIV(4), .BLANK(1)) dut_a (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus_a.slave),
    .seg_n       (seg_a),
    .dp_n        (dp_a),
    .an_n        (an_a),
    .frame_start (fs_a)
  );

  seg_scan #(.DIGITS(3), .DIV(2), .BLANK(1)) dut_b (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus_b.slave),
    .seg_n       (seg_b),
    .dp_n        (dp_b),
    .an_n        (an_b),
    .frame_start (fs_b)
  );

  int checks = 0;
  int errors = 0;
  int k = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h (k=%0d)", tag, got, exp, k);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic run_to(input int n);
    while (k < n) step();
  endtask

  task automatic idle_a();
    bus_a.wr_en = 1'b0; bus_a.wr_addr = '0; bus_a.wr_code = '0; bus_a.wr_dp = 1'b0;
    bus_a.commit = 1'b0;
  endtask

  task automatic idle_b();
    bus_b.wr_en = 1'b0; bus_b.wr_addr = '0; bus_b.wr_code = '0; bus_b.wr_dp = 1'b0;
    bus_b.commit = 1'b0;
  endtask

  task automatic wr_a(input logic [1:0] a, input logic [3:0] c, input logic d);
    bus_a.wr_en = 1'b1; bus_a.wr_addr = a; bus_a.wr_code = c; bus_a.wr_dp = d;
  endtask

  task automatic wr_b(input logic [1:0] a, input logic [3:0] c);
    bus_b.wr_en = 1'b1; bus_b.wr_addr = a; bus_b.wr_code = c; bus_b.wr_dp = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_a();
    idle_b();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_an", an_a, 4'hF);
    chk("rst_seg", seg_a, 7'h7F);
    chk("rst_dp", dp_a, 1'b1);
    chk("rst_pend", bus_a.pending, 1'b0);
    chk("rst_cd", bus_a.commit_done, 1'b0);
    chk("rst_fs", fs_a, 1'b0);
    chk("rst_an_b", an_b, 3'h7);

    @(negedge clk);
    rst_n = 1'b1;
    k = 0;

    // Blank display scan after reset
    step();
    chk("fs_first", fs_a, 1'b1);
    chk("an_k1", an_a, 4'hF);
    step();
    chk("an_k2", an_a, 4'hE);
    chk("seg_k2", seg_a, 7'h7F);
    chk("fs_k2", fs_a, 1'b0);
    run_to(5);
    chk("an_k5", an_a, 4'hF);
    step();
    chk("an_k6", an_a, 4'hD);
    chk("seg_k6", seg_a, 7'h7F);

    // Shadow writes {3,14,0,9}; instance B writes out-of-range addr 3 then addr 0
    wr_a(2'd0, 4'd3, 1'b0); wr_b(2'd3, 4'd8);
    step();
    wr_a(2'd1, 4'd14, 1'b0); wr_b(2'd0, 4'd1);
    step();
    wr_a(2'd2, 4'd0, 1'b0); idle_b(); bus_b.commit = 1'b1;
    step();
    wr_a(2'd3, 4'd9, 1'b0); idle_b();
    step();
    idle_a(); bus_a.commit = 1'b1;
    chk("no_early_show", seg_a, 7'h7F);
    chk("an_k10", an_a, 4'hB);
    step();
    idle_a();
    chk("pend_set", bus_a.pending, 1'b1);
    chk("cd_idle", bus_a.commit_done, 1'b0);
    step();
    chk("cd_b", bus_b.commit_done, 1'b1);
    bus_a.commit = 1'b1;
    step();
    idle_a();
    chk("pend_recommit", bus_a.pending, 1'b1);
    step();
    chk("b_an_d0", an_b, 3'b110);
    chk("b_seg_d0", seg_b, 7'h79);
    step();
    chk("pend_k15", bus_a.pending, 1'b1);
    chk("cd_k15", bus_a.commit_done, 1'b0);
    step();
    chk("cd_pulse", bus_a.commit_done, 1'b1);
    chk("pend_clr", bus_a.pending, 1'b0);
    chk("b_an_d1", an_b, 3'b101);
    chk("b_seg_d1", seg_b, 7'h7F);
    step();
    chk("cd_once", bus_a.commit_done, 1'b0);
    chk("pend_k17", bus_a.pending, 1'b0);
    chk("fs_k17", fs_a, 1'b1);
    chk("an_k17", an_a, 4'hF);
    step();
    chk("an_d0", an_a, 4'hE);
    chk("seg_d0", seg_a, 7'h30);
    chk("dp_d0", dp_a, 1'b1);
    chk("b_an_d2", an_b, 3'b011);
    chk("b_seg_d2", seg_b, 7'h7F);
    run_to(22);
    chk("an_d1", an_a, 4'hD);
    chk("seg_d1", seg_a, 7'h3F);
    run_to(26);
    chk("an_d2", an_a, 4'hB);
    chk("seg_d2", seg_a, 7'h40);
    run_to(30);
    chk("an_d3", an_a, 4'h7);
    chk("seg_d3", seg_a, 7'h10);

    // Write without commit leaves the display alone
    wr_a(2'd0, 4'd8, 1'b0);
    step();
    idle_a();
    run_to(34);
    chk("nocommit_f1", seg_a, 7'h30);
    chk("nocommit_pend", bus_a.pending, 1'b0);
    run_to(48);
    chk("nocommit_cd1", bus_a.commit_done, 1'b0);
    run_to(50);
    chk("nocommit_f2", seg_a, 7'h30);
    run_to(64);
    chk("nocommit_cd2", bus_a.commit_done, 1'b0);
    run_to(66);
    chk("nocommit_f3", seg_a, 7'h30);
    chk("nocommit_pend3", bus_a.pending, 1'b0);

    // Commit and write on the boundary cycle itself
    run_to(79);
    bus_a.commit = 1'b1;
    wr_a(2'd2, 4'd5, 1'b0);
    step();
    idle_a();
    chk("bnd_cd", bus_a.commit_done, 1'b1);
    chk("bnd_pend", bus_a.pending, 1'b0);
    step();
    chk("bnd_pend_after", bus_a.pending, 1'b0);
    run_to(82);
    chk("bnd_d0", seg_a, 7'h00);
    run_to(90);
    chk("bnd_an_d2", an_a, 4'hB);
    chk("bnd_seg_d2", seg_a, 7'h12);

    // Decimal point on digit 1
    wr_a(2'd1, 4'd7, 1'b1);
    step();
    idle_a(); bus_a.commit = 1'b1;
    step();
    idle_a();
    run_to(96);
    chk("dp_cd", bus_a.commit_done, 1'b1);
    run_to(98);
    chk("dp_d0_off", dp_a, 1'b1);
    chk("dp_d0_seg", seg_a, 7'h00);
    run_to(102);
    chk("dp_an_d1", an_a, 4'hD);
    chk("dp_seg_d1", seg_a, 7'h78);
    chk("dp_on_d1", dp_a, 1'b0);

    // Asynchronous reset mid-slot while a commit is pending
    run_to(103);
    bus_a.commit = 1'b1;
    step();
    idle_a();
    chk("pre_rst_pend", bus_a.pending, 1'b1);
    run_to(106);
    chk("pre_rst_an", an_a, 4'hB);
    chk("pre_rst_seg", seg_a, 7'h12);
    rst_n = 1'b0;
    #1;
    chk("arst_an", an_a, 4'hF);
    chk("arst_seg", seg_a, 7'h7F);
    chk("arst_dp", dp_a, 1'b1);
    chk("arst_pend", bus_a.pending, 1'b0);
    chk("arst_cd", bus_a.commit_done, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    run_to(2);
    chk("post_an_d0", an_a, 4'hE);
    chk("post_seg_d0", seg_a, 7'h7F);
    run_to(6);
    chk("post_seg_d1", seg_a, 7'h7F);
    run_to(10);
    chk("post_seg_d2", seg_a, 7'h7F);
    run_to(14);
    chk("post_an_d3", an_a, 4'h7);
    chk("post_seg_d3", seg_a, 7'h7F);
    chk("post_dp_d3", dp_a, 1'b1);

    // Shadow was cleared too: committing it keeps everything blank
    bus_a.commit = 1'b1;
    step();
    idle_a();
    step();
    chk("post_cd", bus_a.commit_done, 1'b1);
    run_to(18);
    chk("post_sh_d0", seg_a, 7'h7F);
    run_to(26);
    chk("post_sh_d2", seg_a, 7'h7F);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
